// File: rtl/alu_sched_pkg.sv
// Shared types and helpers for the scheduled three-lane integer ALU.
// Opcode encodings, the opcode-to-lane mapping and the deepest-lane
// computation live here so the top level and any future lanes agree on them.
package alu_sched_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_MUL     = 3'b010,
        OP_MULH    = 3'b011,
        OP_AND     = 3'b100,
        OP_OR      = 3'b101,
        OP_XOR     = 3'b110,
        OP_ILLEGAL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        LANE_LOGIC = 2'd0,
        LANE_ADD   = 2'd1,
        LANE_MUL   = 2'd2
    } lane_e;

    // Status flags that travel alongside every result.
    typedef struct packed {
        logic overflow;
        logic zero;
        logic exception;
    } alu_flags_t;

    // Illegal opcodes ride the logic lane so they still retire with a tag.
    function automatic lane_e lane_sel(input logic [2:0] op);
        lane_e lane;
        case (op)
            3'b000, 3'b001: lane = LANE_ADD;
            3'b010, 3'b011: lane = LANE_MUL;
            default:        lane = LANE_LOGIC;
        endcase
        return lane;
    endfunction

    // Depth of the deepest lane, which sets the length of the occupancy vector.
    function automatic int max_stages(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/lat_pipe.sv
// Fixed-depth delay line with a valid bit per stage. The last stage is the
// lane head; flush kills every valid bit in one edge while data is left alone.
module lat_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         any_valid
);

    logic [DEPTH-1:0] valid_q;
    logic [W-1:0]     data_q [DEPTH];

    // Valid bits shift one stage per edge and are cleared by flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Payload shifts in lockstep with the valid bits; it is only meaningful where valid is set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            data_q[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign any_valid = |valid_q;

endmodule

// File: rtl/pipe_alu_sched.sv
// Scheduled integer ALU with logic, add/sub and multiply lanes sharing one
// registered result port. Results are computed at issue and carried down a
// per-lane delay line; the scheduler refuses any op whose lane head would fill
// on the same edge as an op already in flight, so the heads are one-hot and the
// output register never sees two results at once. in_ready is combinational
// from in_op, flush and reset.
module pipe_alu_sched
    import alu_sched_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int TAG_W        = 4,
    parameter int LOGIC_STAGES = 1,
    parameter int ADD_STAGES   = 2,
    parameter int MUL_STAGES   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_exception,
    output logic             busy
);

    localparam int MAX_STAGES = max_stages(LOGIC_STAGES, ADD_STAGES, MUL_STAGES);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
        alu_flags_t       flags;
    } payload_t;

    localparam int PW = $bits(payload_t);

    lane_e                 req_lane;
    int                    req_lat;
    logic                  slot_taken;
    logic                  accept;

    logic [MAX_STAGES:1]   occ;
    logic [MAX_STAGES:1]   occ_next;
    logic [MAX_STAGES+1:1] occ_ext;

    logic [WIDTH-1:0]      sum;
    logic [WIDTH-1:0]      diff;
    logic [2*WIDTH-1:0]    prod;
    payload_t              issue_payload;

    logic                  logic_hv, add_hv, mul_hv;
    logic                  logic_any, add_any, mul_any;
    logic [PW-1:0]         logic_head, add_head, mul_head;
    logic [PW-1:0]         head_bits;
    payload_t              head_sel;
    logic                  any_head;

    // Pick the lane and its latency for the op currently presented.
    always_comb begin
        req_lane = lane_sel(in_op);
        req_lat  = LOGIC_STAGES;
        case (req_lane)
            LANE_ADD: req_lat = ADD_STAGES;
            LANE_MUL: req_lat = MUL_STAGES;
            default:  req_lat = LOGIC_STAGES;
        endcase
    end

    // An op of latency L fills its lane head L edges from now; refuse it if that slot is booked.
    always_comb begin
        slot_taken = 1'b0;
        for (int k = 1; k <= MAX_STAGES; k++) begin
            if (req_lat == k) slot_taken = occ[k];
        end
    end

    assign in_ready = reset & ~flush & ~slot_taken;
    assign accept   = in_valid & in_ready;

    // Advance the booking vector one edge and book the slot of a newly accepted op.
    always_comb begin
        occ_ext  = {1'b0, occ};
        occ_next = '0;
        for (int k = 1; k <= MAX_STAGES; k++) begin
            occ_next[k] = occ_ext[k+1] | (accept && (req_lat == k + 1));
        end
    end

    // Booking vector register; bit k means some lane head fills k edges from now.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ <= '0;
        end else if (flush) begin
            occ <= '0;
        end else begin
            occ <= occ_next;
        end
    end

    assign sum  = in_a + in_b;
    assign diff = in_a - in_b;
    assign prod = {{WIDTH{in_a[WIDTH-1]}}, in_a} * {{WIDTH{in_b[WIDTH-1]}}, in_b};

    // Compute result and flags at issue; the lanes only delay them.
    always_comb begin
        issue_payload                 = '0;
        issue_payload.tag             = in_tag;
        case (alu_op_e'(in_op))
            OP_ADD: begin
                issue_payload.result         = sum;
                issue_payload.flags.overflow = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                                               (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                issue_payload.result         = diff;
                issue_payload.flags.overflow = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                                               (diff[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_MUL: begin
                issue_payload.result         = prod[WIDTH-1:0];
                issue_payload.flags.overflow = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
            end
            OP_MULH: issue_payload.result = prod[2*WIDTH-1:WIDTH];
            OP_AND:  issue_payload.result = in_a & in_b;
            OP_OR:   issue_payload.result = in_a | in_b;
            OP_XOR:  issue_payload.result = in_a ^ in_b;
            default: issue_payload.flags.exception = 1'b1;
        endcase
        issue_payload.flags.zero = (issue_payload.result == '0);
    end

    lat_pipe #(.DEPTH(LOGIC_STAGES), .W(PW)) u_logic_lane (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (accept && (req_lane == LANE_LOGIC)),
        .in_data   (issue_payload),
        .out_valid (logic_hv),
        .out_data  (logic_head),
        .any_valid (logic_any)
    );

    lat_pipe #(.DEPTH(ADD_STAGES), .W(PW)) u_add_lane (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (accept && (req_lane == LANE_ADD)),
        .in_data   (issue_payload),
        .out_valid (add_hv),
        .out_data  (add_head),
        .any_valid (add_any)
    );

    lat_pipe #(.DEPTH(MUL_STAGES), .W(PW)) u_mul_lane (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (accept && (req_lane == LANE_MUL)),
        .in_data   (issue_payload),
        .out_valid (mul_hv),
        .out_data  (mul_head),
        .any_valid (mul_any)
    );

    // Heads are one-hot, so an AND-OR mux is enough to pick the completing lane.
    always_comb begin
        head_bits = '0;
        if (logic_hv) head_bits = head_bits | logic_head;
        if (add_hv)   head_bits = head_bits | add_head;
        if (mul_hv)   head_bits = head_bits | mul_head;
        head_sel  = payload_t'(head_bits);
        any_head  = logic_hv | add_hv | mul_hv;
    end

    // Result register: strobe for one cycle, hold the last result otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_tag       <= '0;
            out_overflow  <= 1'b0;
            out_zero      <= 1'b0;
            out_exception <= 1'b0;
        end else if (flush) begin
            out_valid     <= 1'b0;
        end else begin
            out_valid <= any_head;
            if (any_head) begin
                out_result    <= head_sel.result;
                out_tag       <= head_sel.tag;
                out_overflow  <= head_sel.flags.overflow;
                out_zero      <= head_sel.flags.zero;
                out_exception <= head_sel.flags.exception;
            end
        end
    end

    assign busy = logic_any | add_any | mul_any;

endmodule

// File: doc/pipe_alu_sched.md
Name: pipe_alu_sched

Overview:
- Parametrised integer ALU with three fixed-latency execution lanes: logic, add/sub and multiply.
- Ready/valid issue port with a tag carried through to the result.
- A single shared result port; an issue scheduler refuses any op whose completion would collide on that port with an op already in flight.
- Sits between the operand-fetch stage and writeback in the static-latency datapath.
- Successor to the fixed always-valid FP ALU: it adds width, per-lane depth, tags, flags, flush and hazard-free result arbitration.

Parameters:
- WIDTH, 32, operand and result width in bits (>=8).
- TAG_W, 4, width of the tag carried with each op (>=1).
- LOGIC_STAGES, 1, logic-lane latency in cycles (1..8).
- ADD_STAGES, 2, add/sub-lane latency in cycles (1..8).
- MUL_STAGES, 3, multiply-lane latency in cycles (1..8).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; kills all in-flight ops.
- in_valid  in  1  op presented.
- in_ready  out  1  op will be accepted this cycle.
- in_op  in  3  opcode, encodings in Behaviour.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  one-cycle result strobe.
- out_result  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the completing op.
- out_overflow  out  1  signed overflow.
- out_zero  out  1  result == 0.
- out_exception  out  1  illegal opcode.
- busy  out  1  at least one op in flight.

Behaviour:
- Reset (reset low, asynchronous): all outputs and internal state 0. in_ready is 0 while reset is asserted.
- Opcodes:
  - 000 ADD, 001 SUB, 010 MUL (low WIDTH bits of the signed product), 011 MULH (high WIDTH bits of the signed product).
  - 100 AND, 101 OR, 110 XOR, 111 illegal.
  - ADD/SUB use ADD_STAGES. MUL/MULH use MUL_STAGES. AND/OR/XOR and illegal use LOGIC_STAGES.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - out_overflow=1 when the signed add/sub result overflows, or for MUL when the high half is not the sign-extension of the low half.
  - out_overflow=0 for MULH, logic ops and illegal.
  - out_zero is computed on out_result.
  - Illegal op: out_result=0, out_zero=1, out_exception=1.
- Accept and latency:
  - An op is accepted on a rising edge when in_valid & in_ready.
  - With lane latency L, out_valid is high for exactly the one cycle following the L-th rising edge after acceptance. Results, tags and flags appear together.
  - At most one op is accepted per cycle.
- Scheduler:
  - Keeps an occupancy vector of MAX_STAGES bits; bit k means a result will complete k edges from now. The vector shifts down by one each edge.
  - in_ready = !reset_active & !flush & !occupied[L(in_op)] (combinational from in_op; documented as such).
  - Equal-latency ops never conflict. Ops of different latency may conflict, e.g. MUL at cycle t followed by ADD at t+1, both targeting t+3. The younger op is stalled; the older op is never delayed.
  - Completion order follows completion time, not issue order; the tag identifies each op.
- Output registers: out_* hold their values when out_valid=0, apart from out_valid itself.
- flush:
  - Clears all lane valid bits and the occupancy vector on the next edge. in_ready=0 in the flush cycle, so no op is accepted.
  - out_valid=0 from the next cycle until a new op completes.
  - An op completing on the same edge as flush is dropped.
- busy: OR of all lane valid bits.
- Reset mid-operation: in-flight ops are discarded and nothing is emitted after reset is released.

Decomposition:
- Package alu_sched_pkg holds:
  - the opcode enum;
  - a lane-select function mapping opcode to lane;
  - the MAX_STAGES computation;
  - a result struct {result, tag, overflow, zero, exception}.
- Sub-module lat_pipe: a parametrised delay line (DEPTH, payload width) with valid, flush and asynchronous active-low reset. It is instantiated once per lane.
- The top level holds the operators, scheduler, and an output mux/register over lane heads, which are one-hot by construction.

Test Plan:
- Reset: hold reset low with in_valid=1 -> in_ready=0, out_valid=0, busy=0. After release, ADD 5+7 tag 3 -> out_valid 2 cycles later with result 12, tag 3, zero=0.
- Overflow flags:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1.
  - SUB 0-0 -> 0, zero=1.
  - MUL 0x10000*0x10000 -> 0, overflow=1.
  - MULH 0xFFFFFFFF*0xFFFFFFFF -> 0, overflow=0.
- Collision: MUL (tag 1) at cycle 0, ADD (tag 2) at cycle 1 -> in_ready=0 at cycle 1. ADD is accepted at cycle 2. Outputs appear at cycle 3 (tag 1) and cycle 4 (tag 2); no output is lost.
- Reordering: MUL tag 1, then XOR tag 2 the next cycle -> XOR completes first (cycle 2, tag 2), MUL at cycle 3 (tag 1).
- Throughput: 20 back-to-back ADDs -> in_ready stays 1 and 20 consecutive out_valid pulses appear in order.
- Flush and illegal op: op 111 issued, then flush asserted one cycle later -> no out_valid and busy=0. An illegal op without flush -> exception=1, result=0 after 1 cycle.
